// File: rtl/riffa_chnl_engine_if.sv
// One RIFFA channel (RX + TX halves). master = the user-side engine, slave = the RIFFA core.
interface riffa_chnl_if #(
  parameter int C_PCI_DATA_WIDTH = 128
);
  logic                        CHNL_RX_CLK;
  logic                        CHNL_RX;
  logic                        CHNL_RX_ACK;
  logic                        CHNL_RX_LAST;
  logic [31:0]                 CHNL_RX_LEN;
  logic [30:0]                 CHNL_RX_OFF;
  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
  logic                        CHNL_RX_DATA_VALID;
  logic                        CHNL_RX_DATA_REN;
  logic                        CHNL_TX_CLK;
  logic                        CHNL_TX;
  logic                        CHNL_TX_ACK;
  logic                        CHNL_TX_LAST;
  logic [31:0]                 CHNL_TX_LEN;
  logic [30:0]                 CHNL_TX_OFF;
  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA;
  logic                        CHNL_TX_DATA_VALID;
  logic                        CHNL_TX_DATA_REN;

  modport master (
    output CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
           CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
           CHNL_TX_DATA, CHNL_TX_DATA_VALID,
    input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA,
           CHNL_RX_DATA_VALID, CHNL_TX_ACK, CHNL_TX_DATA_REN
  );
  modport slave (
    input  CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
           CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
           CHNL_TX_DATA, CHNL_TX_DATA_VALID,
    output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA,
           CHNL_RX_DATA_VALID, CHNL_TX_ACK, CHNL_TX_DATA_REN
  );
endinterface

// File: rtl/riffa_chnl_engine.sv
// RIFFA channel test engine: pattern check+reply, FIFO loopback or sink, with
// saturating error / transaction counters for PCIe bring-up.
module riffa_chnl_lane #(
  parameter int LANE = 0
) (
  input  logic [31:0] rx_base,
  input  logic [31:0] tx_base,
  input  logic [31:0] rx_word,
  input  logic [31:0] vld_lanes,
  output logic        mis,
  output logic [31:0] tx_word
);
  localparam logic [31:0] IDX = 32'(LANE);
  assign mis     = (IDX < vld_lanes) && (rx_word != rx_base + IDX);
  assign tx_word = tx_base + IDX;
endmodule

module riffa_chnl_engine #(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_FIFO_DEPTH     = 512,
  parameter int C_CNT_W          = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         MODE,
  riffa_chnl_if.master       ch,
  output logic [C_CNT_W-1:0] ERR_CNT,
  output logic [C_CNT_W-1:0] DONE_CNT
);
  localparam int          L     = C_PCI_DATA_WIDTH / 32;
  localparam int          LOG2L = $clog2(L);
  localparam int          AW    = $clog2(C_FIFO_DEPTH);
  localparam int          EW    = C_CNT_W + 3;
  localparam logic [31:0] LANES = 32'(L);

  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_nxt;

  logic [31:0] len_q, rx_cnt, tx_cnt, nbeats, len_mod, vld_lanes, rx_base, tx_base;
  logic [32:0] len_rnd;
  logic [1:0]  mode_q;
  logic        ack_q, rx_done, tx_done, tx_on;
  logic        start, xfer_end, rx_fire, tx_fire, tx_last, tx_vld, lpbk, sink;
  logic [AW:0] wptr, rptr;
  logic        fifo_full, fifo_empty;
  logic [C_PCI_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [L-1:0]            mis;
  logic [L-1:0][31:0]      tx_pat;
  logic [EW-1:0]           mis_cnt, err_sum;
  logic                    unused_in;

  assign unused_in = ^{ch.CHNL_RX_LAST, ch.CHNL_RX_OFF, ch.CHNL_TX_ACK};

  assign lpbk       = (mode_q == 2'd1);
  assign sink       = (mode_q == 2'd2);
  assign len_rnd    = {1'b0, len_q} + 33'(L - 1);
  assign nbeats     = 32'(len_rnd >> LOG2L);
  assign len_mod    = len_q % LANES;
  assign vld_lanes  = (rx_cnt == nbeats - 32'd1 && len_mod != 32'd0) ? len_mod : LANES;
  assign rx_base    = rx_cnt * LANES;
  assign tx_base    = tx_cnt * LANES;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign ch.CHNL_RX_DATA_REN = (state == XFER) && !rx_done && (!lpbk || !fifo_full);
  assign rx_fire = ch.CHNL_RX_DATA_VALID && ch.CHNL_RX_DATA_REN;
  assign tx_vld  = tx_on && (lpbk ? !fifo_empty : (tx_cnt < nbeats));
  assign tx_fire = tx_vld && ch.CHNL_TX_DATA_REN;
  // zero-length transfers retire TX immediately so CHNL_TX is a single-cycle pulse
  assign tx_last = tx_on && ((nbeats == 32'd0) || (tx_fire && tx_cnt == nbeats - 32'd1));

  for (genvar i = 0; i < L; i++) begin : g_lane
    riffa_chnl_lane #(.LANE(i)) u_lane (
      .rx_base  (rx_base),
      .tx_base  (tx_base),
      .rx_word  (ch.CHNL_RX_DATA[32*i +: 32]),
      .vld_lanes(vld_lanes),
      .mis      (mis[i]),
      .tx_word  (tx_pat[i])
    );
  end

  always_comb begin
    mis_cnt = '0;
    for (int i = 0; i < L; i++) mis_cnt = mis_cnt + EW'(mis[i]);
  end
  assign err_sum = EW'(ERR_CNT) + mis_cnt;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    xfer_end  = 1'b0;
    case (state)
      IDLE: if (ch.CHNL_RX) begin
        start     = 1'b1;
        state_nxt = XFER;
      end
      XFER: if (rx_done && (tx_done || sink)) begin
        xfer_end  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      len_q    <= '0;
      mode_q   <= '0;
      ack_q    <= 1'b0;
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      rx_done  <= 1'b0;
      tx_done  <= 1'b0;
      tx_on    <= 1'b0;
      ERR_CNT  <= '0;
      DONE_CNT <= '0;
    end else begin
      state <= state_nxt;
      ack_q <= start;
      if (start) begin
        len_q   <= ch.CHNL_RX_LEN;
        mode_q  <= (MODE == 2'd3) ? 2'd0 : MODE;
        rx_cnt  <= '0;
        tx_cnt  <= '0;
        rx_done <= (ch.CHNL_RX_LEN == 32'd0);
        tx_done <= 1'b0;
        tx_on   <= (MODE == 2'd1);
      end else if (state == XFER) begin
        if (rx_fire) begin
          rx_cnt <= rx_cnt + 32'd1;
          if (rx_cnt == nbeats - 32'd1) rx_done <= 1'b1;
        end
        if (tx_fire) tx_cnt <= tx_cnt + 32'd1;
        if (tx_last) begin
          tx_on   <= 1'b0;
          tx_done <= 1'b1;
        end else if (rx_done && !sink && !lpbk && !tx_on && !tx_done) begin
          tx_on <= 1'b1;
        end
      end
      if (rx_fire && !lpbk)
        ERR_CNT <= (err_sum[EW-1:C_CNT_W] != '0) ? '1 : err_sum[C_CNT_W-1:0];
      if (xfer_end && DONE_CNT != '1) DONE_CNT <= DONE_CNT + C_CNT_W'(1);
    end
  end

  // loopback FIFO: first-word-fall-through head drives TX data directly
  always_ff @(posedge CLK)
    if (rx_fire && lpbk) mem[wptr[AW-1:0]] <= ch.CHNL_RX_DATA;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (rx_fire && lpbk) wptr <= wptr + 1'b1;
      if (tx_fire && lpbk) rptr <= rptr + 1'b1;
    end
  end

  assign ch.CHNL_RX_CLK        = CLK;
  assign ch.CHNL_TX_CLK        = CLK;
  assign ch.CHNL_RX_ACK        = ack_q;
  assign ch.CHNL_TX            = tx_on;
  assign ch.CHNL_TX_LAST       = 1'b1;
  assign ch.CHNL_TX_LEN        = len_q;
  assign ch.CHNL_TX_OFF        = '0;
  assign ch.CHNL_TX_DATA_VALID = tx_vld;
  assign ch.CHNL_TX_DATA       = tx_on ? (lpbk ? mem[rptr[AW-1:0]] : tx_pat) : '0;
endmodule
